// File: rtl/somador_pkg.sv
// Shared definitions for the mixed-signedness accumulator adder: operation codes
// and output range-bound helpers.
package somador_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Wide enough for the WA+3 exact result at the largest supported WA (32).
  localparam int unsigned BOUND_W = 36;
  typedef logic signed [BOUND_W-1:0] bound_t;

  function automatic bound_t range_max(input int unsigned w, input logic sgn);
    bound_t one;
    one = bound_t'(1);
    return sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  function automatic bound_t range_min(input int unsigned w, input logic sgn);
    bound_t one;
    one = bound_t'(1);
    return sgn ? -(one <<< (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/estende_sinal.sv
// Operand width extension: sign-extends when sgn=1, zero-extends otherwise.
module estende_sinal #(
  parameter int unsigned WI = 4,
  parameter int unsigned WO = 8
) (
  input  logic [WI-1:0] din,
  input  logic          sgn,
  output logic [WO-1:0] dout
);

  always_comb begin
    if (sgn) dout = {{(WO - WI){din[WI-1]}}, din};
    else     dout = {{(WO - WI){1'b0}}, din};
  end

endmodule

// File: rtl/somador_misto_acc.sv
// Mixed-signedness adder/subtractor/accumulator with a one-deep valid/ready output register.
// Optional saturation on overflow is enabled by defining SOMADOR_SATURATE_EN.
module somador_misto_acc
  import somador_pkg::*;
#(
  parameter int unsigned WA = 8,
  parameter int unsigned WB = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] op_a,
  input  logic          a_signed,
  input  logic [WB-1:0] op_b,
  input  logic          b_signed,
  input  logic [1:0]    codigo,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA-1:0] resultado,
  output logic          overflow
);

  localparam int unsigned EW = WA + 3;

  logic [EW-1:0] ext_a_raw, ext_b_raw;
  logic signed [EW-1:0] ext_a, ext_b, ext_acc, exact;
  logic [WA-1:0] acc;
  logic [WA-1:0] res_next;
  logic          ovf_next;
  logic          out_signed;
  logic          accept;
  op_e           op;
  bound_t        exact_w, hi_w, lo_w;
  logic          above, below;

  estende_sinal #(.WI(WA), .WO(EW)) u_ext_a (
    .din  (op_a),
    .sgn  (a_signed),
    .dout (ext_a_raw)
  );

  estende_sinal #(.WI(WB), .WO(EW)) u_ext_b (
    .din  (op_b),
    .sgn  (b_signed),
    .dout (ext_b_raw)
  );

  assign ext_a      = ext_a_raw;
  assign ext_b      = ext_b_raw;
  assign out_signed = a_signed || b_signed;
  assign op         = op_e'(codigo);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;

  // The stored accumulator is reinterpreted under the current request's output signedness.
  always_comb begin
    if (out_signed) ext_acc = {{(EW - WA){acc[WA-1]}}, acc};
    else            ext_acc = {{(EW - WA){1'b0}}, acc};
  end

  always_comb begin
    exact = '0;
    case (op)
      OP_ADD:  exact = ext_a + ext_b;
      OP_SUB:  exact = ext_a - ext_b;
      OP_ACC:  exact = ext_acc + ext_a + ext_b;
      default: exact = '0;
    endcase
  end

  always_comb begin
    exact_w  = bound_t'(exact);
    hi_w     = range_max(WA, out_signed);
    lo_w     = range_min(WA, out_signed);
    above    = exact_w > hi_w;
    below    = exact_w < lo_w;
    ovf_next = above || below;
`ifdef SOMADOR_SATURATE_EN
    if (above)      res_next = hi_w[WA-1:0];
    else if (below) res_next = lo_w[WA-1:0];
    else            res_next = exact[WA-1:0];
`else
    res_next = exact[WA-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      resultado <= '0;
      overflow  <= 1'b0;
      acc       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        resultado <= res_next;
        overflow  <= ovf_next;
        if (op == OP_ACC)      acc <= res_next;
        else if (op == OP_CLR) acc <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
